// File: rtl/frac_pkg.sv
// Shared constants and state encoding for the
// quarter-pel search row feeder.
package frac_pkg;

   localparam int ROWS   = 8;
   localparam int PIX_W  = 8;
   localparam int ROW_W  = ROWS * PIX_W;
   localparam int ROW_CW = 3;
   localparam int MV_W   = 3;

   localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_WAIT_RES
   } feed_state_e;

endpackage

// File: rtl/frac_block_feeder_if.sv
// Memory, row-beat and result signals between the
// feeder (master) and its environment (slave).
interface frac_block_feeder_if #(
   parameter int ADDR_W = 12
);
   import frac_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] cur_base;
   logic [ADDR_W-1:0] ref_base;
   logic [ADDR_W-1:0] stride;

   logic              cur_rd_en;
   logic [ADDR_W-1:0] cur_addr;
   logic [ROW_W-1:0]  cur_data;
   logic              ref_rd_en;
   logic [ADDR_W-1:0] ref_addr;
   logic [ROW_W-1:0]  ref_data;

   logic [ROW_W-1:0]  filter_pix;
   logic [ROW_W-1:0]  ref_pix;
   logic              input_ready;

   logic [MV_W-1:0]   mvx;
   logic [MV_W-1:0]   mvy;

   logic              busy;
   logic              done;
   logic [MV_W-1:0]   mv_x_out;
   logic [MV_W-1:0]   mv_y_out;

   modport master (
      input  start, cur_base, ref_base, stride,
      input  cur_data, ref_data, mvx, mvy,
      output cur_rd_en, cur_addr,
      output ref_rd_en, ref_addr,
      output filter_pix, ref_pix, input_ready,
      output busy, done, mv_x_out, mv_y_out
   );

   modport slave (
      output start, cur_base, ref_base, stride,
      output cur_data, ref_data, mvx, mvy,
      input  cur_rd_en, cur_addr,
      input  ref_rd_en, ref_addr,
      input  filter_pix, ref_pix, input_ready,
      input  busy, done, mv_x_out, mv_y_out
   );

endinterface

// File: rtl/frac_addr_gen.sv
// Row address generator: base + r*stride built by
// repeated addition, wrapping modulo 2^ADDR_W.
module frac_addr_gen #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] stride_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;

   // next address: load wins over step
   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      if (load_i) begin
         addr_d   = base_i;
         stride_d = stride_i;
      end else if (step_i) begin
         addr_d = addr_q + stride_q;
      end
   end

   // latched stride and running address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         stride_q <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/frac_block_feeder.sv
// Fetches an 8x8 current/reference block pair and
// streams it as 8 row beats, then captures the MV.
module frac_block_feeder
   import frac_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int RESULT_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   frac_block_feeder_if.master bus
);

   localparam int CNT_W =
      (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;

   feed_state_e       state_q, state_d;
   logic [ROW_CW-1:0] row_q, row_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [MV_W-1:0]   mvx_q, mvx_d;
   logic [MV_W-1:0]   mvy_q, mvy_d;

   logic              dat_vld_q;
   logic              rdy_q;
   logic [ROW_W-1:0]  fpix_q;
   logic [ROW_W-1:0]  rpix_q;

   logic              ag_load;
   logic              ag_step;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] ref_addr;

   frac_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_cur_ag (
      .clk      (clk),
      .reset    (reset),
      .load_i   (ag_load),
      .step_i   (ag_step),
      .base_i   (bus.cur_base),
      .stride_i (bus.stride),
      .addr_o   (cur_addr)
   );

   frac_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_ref_ag (
      .clk      (clk),
      .reset    (reset),
      .load_i   (ag_load),
      .step_i   (ag_step),
      .base_i   (bus.ref_base),
      .stride_i (bus.stride),
      .addr_o   (ref_addr)
   );

   // control FSM: next state and registered outputs
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rd_en_d = rd_en_q;
      mvx_d   = mvx_q;
      mvy_d   = mvy_q;
      ag_load = 1'b0;
      ag_step = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               row_d   = '0;
               busy_d  = 1'b1;
               rd_en_d = 1'b1;
               ag_load = 1'b1;
            end
         end
         ST_FETCH: begin
            if (row_q == LAST_ROW) begin
               state_d = ST_DRAIN;
               rd_en_d = 1'b0;
            end else begin
               row_d   = row_q + 1'b1;
               ag_step = 1'b1;
            end
         end
         ST_DRAIN: begin
            // last beat on the wire, nothing left in flight
            if (rdy_q && !dat_vld_q) begin
               state_d = ST_WAIT_RES;
               cnt_d   = CNT_W'(RESULT_LAT);
            end
         end
         ST_WAIT_RES: begin
            // capture on the edge the counter reaches zero
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mvx_d   = bus.mvx;
               mvy_d   = bus.mvy;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // control FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         mvx_q   <= '0;
         mvy_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
         mvx_q   <= mvx_d;
         mvy_q   <= mvy_d;
      end
   end

   // read-data return tracking and row beat register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_vld_q <= 1'b0;
         rdy_q     <= 1'b0;
         fpix_q    <= '0;
         rpix_q    <= '0;
      end else begin
         dat_vld_q <= rd_en_q;
         rdy_q     <= dat_vld_q;
         if (dat_vld_q) begin
            fpix_q <= bus.cur_data;
            rpix_q <= bus.ref_data;
         end
      end
   end

   assign bus.cur_rd_en   = rd_en_q;
   assign bus.ref_rd_en   = rd_en_q;
   assign bus.cur_addr    = cur_addr;
   assign bus.ref_addr    = ref_addr;
   assign bus.filter_pix  = fpix_q;
   assign bus.ref_pix     = rpix_q;
   assign bus.input_ready = rdy_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mv_x_out    = mvx_q;
   assign bus.mv_y_out    = mvy_q;

endmodule

// File: tb/tb_frac_block_feeder.sv
// Directed bench for frac_block_feeder: two instances,
// RESULT_LAT=1 (main) and RESULT_LAT=3 (latency).
module tb_frac_block_feeder;

   logic clk;
   logic reset;

   int total = 0;
   int bad   = 0;

   frac_block_feeder_if #(.ADDR_W(12)) bus_a ();
   frac_block_feeder_if #(.ADDR_W(12)) bus_b ();

   frac_block_feeder #(
      .ADDR_W     (12),
      .RESULT_LAT (1)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   frac_block_feeder #(
      .ADDR_W     (12),
      .RESULT_LAT (3)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] cur_word(input logic [11:0] a);
      return {4{4'hC, a}};
   endfunction

   function automatic logic [63:0] ref_word(input logic [11:0] a);
      return {4{4'h5, a}};
   endfunction

   // line memories: one cycle read latency
   always @(posedge clk) begin
      if (bus_a.cur_rd_en) bus_a.cur_data <= cur_word(bus_a.cur_addr);
      if (bus_a.ref_rd_en) bus_a.ref_data <= ref_word(bus_a.ref_addr);
      if (bus_b.cur_rd_en) bus_b.cur_data <= cur_word(bus_b.cur_addr);
      if (bus_b.ref_rd_en) bus_b.ref_data <= ref_word(bus_b.ref_addr);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic kick(input logic [11:0] cb, input logic [11:0] rb,
                       input logic [11:0] st);
      bus_a.cur_base = cb;
      bus_a.ref_base = rb;
      bus_a.stride   = st;
      bus_a.start    = 1'b1;
   endtask

   // called at the negedge where start is already high;
   // checks cycles 1..12 after the accepting edge
   task automatic run_burst(input logic [11:0] cb, input logic [11:0] rb,
                            input logic [11:0] st, input logic [15:0] mask,
                            input logic [2:0] xm, input logic [2:0] ym,
                            input logic [2:0] px, input logic [2:0] py);
      logic [11:0] ea, er;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("c%0d cur_rd_en", k), 64'(bus_a.cur_rd_en), 64'(k <= 8));
         chk($sformatf("c%0d ref_rd_en", k), 64'(bus_a.ref_rd_en), 64'(k <= 8));
         if (k <= 8) begin
            ea = cb + 12'(k - 1) * st;
            er = rb + 12'(k - 1) * st;
            chk($sformatf("c%0d cur_addr", k), 64'(bus_a.cur_addr), 64'(ea));
            chk($sformatf("c%0d ref_addr", k), 64'(bus_a.ref_addr), 64'(er));
         end
         chk($sformatf("c%0d input_ready", k), 64'(bus_a.input_ready),
             64'(k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) begin
            ea = cb + 12'(k - 3) * st;
            er = rb + 12'(k - 3) * st;
            chk($sformatf("c%0d filter_pix", k), bus_a.filter_pix, cur_word(ea));
            chk($sformatf("c%0d ref_pix", k), bus_a.ref_pix, ref_word(er));
         end
         if (k == 11) begin
            ea = cb + 12'd7 * st;
            chk("hold filter_pix", bus_a.filter_pix, cur_word(ea));
         end
         chk($sformatf("c%0d busy", k), 64'(bus_a.busy), 64'(k <= 11));
         chk($sformatf("c%0d done", k), 64'(bus_a.done), 64'(k == 12));
         chk($sformatf("c%0d mv_x_out", k), 64'(bus_a.mv_x_out),
             64'((k == 12) ? xm : px));
         chk($sformatf("c%0d mv_y_out", k), 64'(bus_a.mv_y_out),
             64'((k == 12) ? ym : py));
         bus_a.start = mask[k];
         if (k == 1) begin
            bus_a.cur_base = ~cb;
            bus_a.ref_base = ~rb;
            bus_a.stride   = ~st;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      reset          = 1'b0;
      bus_a.start    = 1'b0;
      bus_a.cur_base = '0;
      bus_a.ref_base = '0;
      bus_a.stride   = '0;
      bus_a.mvx      = '0;
      bus_a.mvy      = '0;
      bus_b.start    = 1'b0;
      bus_b.cur_base = '0;
      bus_b.ref_base = '0;
      bus_b.stride   = '0;
      bus_b.mvx      = '0;
      bus_b.mvy      = '0;
      repeat (2) @(negedge clk);

      chk("rst busy", 64'(bus_a.busy), 64'(0));
      chk("rst done", 64'(bus_a.done), 64'(0));
      chk("rst input_ready", 64'(bus_a.input_ready), 64'(0));
      chk("rst cur_rd_en", 64'(bus_a.cur_rd_en), 64'(0));
      chk("rst cur_addr", 64'(bus_a.cur_addr), 64'(0));
      chk("rst filter_pix", bus_a.filter_pix, 64'(0));
      chk("rst mv_x_out", 64'(bus_a.mv_x_out), 64'(0));
      chk("rst b busy", 64'(bus_b.busy), 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // basic: 0x010/0x200 stride 0x040, last row 0x1D0/0x3C0
      bus_a.mvx = 3'd3;
      bus_a.mvy = 3'd0;
      kick(12'h010, 12'h200, 12'h040);
      run_burst(12'h010, 12'h200, 12'h040, 16'h0000,
                3'd3, 3'd0, 3'd0, 3'd0);
      @(negedge clk);

      // address wrap: 0xFC0, 0xFE0, 0x000 ... 0x0A0
      bus_a.mvx = 3'd1;
      bus_a.mvy = 3'd2;
      kick(12'hFC0, 12'hFF0, 12'h020);
      run_burst(12'hFC0, 12'hFF0, 12'h020, 16'h0000,
                3'd1, 3'd2, 3'd3, 3'd0);
      @(negedge clk);

      // start pulses while busy, cycles 2 and 6
      bus_a.mvx = 3'd4;
      bus_a.mvy = 3'd7;
      kick(12'h031, 12'h500, 12'h011);
      run_burst(12'h031, 12'h500, 12'h011, 16'h0044,
                3'd4, 3'd7, 3'd1, 3'd2);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | bus_a.done | bus_a.input_ready | bus_a.busy;
      end
      chk("busy start ignored", 64'(seen), 64'(0));

      // back-to-back: start in the done cycle
      bus_a.mvx = 3'd2;
      bus_a.mvy = 3'd1;
      kick(12'h100, 12'h300, 12'h008);
      run_burst(12'h100, 12'h300, 12'h008, 16'h1000,
                3'd2, 3'd1, 3'd4, 3'd7);
      bus_a.cur_base = 12'h400;
      bus_a.ref_base = 12'h600;
      bus_a.stride   = 12'h080;
      bus_a.mvx      = 3'd5;
      bus_a.mvy      = 3'd6;
      run_burst(12'h400, 12'h600, 12'h080, 16'h0000,
                3'd5, 3'd6, 3'd2, 3'd1);
      @(negedge clk);

      // reset in cycle 5 of a burst
      bus_a.mvx = 3'd7;
      bus_a.mvy = 3'd7;
      kick(12'h020, 12'h120, 12'h010);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus_a.start = 1'b0;
      end
      chk("pre-abort input_ready", 64'(bus_a.input_ready), 64'(1));
      reset = 1'b0;
      #1;
      chk("abort input_ready", 64'(bus_a.input_ready), 64'(0));
      chk("abort cur_rd_en", 64'(bus_a.cur_rd_en), 64'(0));
      chk("abort ref_rd_en", 64'(bus_a.ref_rd_en), 64'(0));
      chk("abort busy", 64'(bus_a.busy), 64'(0));
      chk("abort cur_addr", 64'(bus_a.cur_addr), 64'(0));
      chk("abort ref_pix", bus_a.ref_pix, 64'(0));
      chk("abort mv_x_out", 64'(bus_a.mv_x_out), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (14) begin
         @(negedge clk);
         seen = seen | bus_a.done | bus_a.input_ready | bus_a.busy;
      end
      chk("post-abort quiet", 64'(seen), 64'(0));
      kick(12'h020, 12'h120, 12'h010);
      run_burst(12'h020, 12'h120, 12'h010, 16'h0000,
                3'd7, 3'd7, 3'd0, 3'd0);
      @(negedge clk);

      // RESULT_LAT=3: done at cycle 14, mv sampled at edge 13
      bus_b.mvx      = 3'd1;
      bus_b.mvy      = 3'd2;
      bus_b.cur_base = 12'h080;
      bus_b.ref_base = 12'h180;
      bus_b.stride   = 12'h008;
      bus_b.start    = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         bus_b.start = 1'b0;
         chk($sformatf("lat c%0d done", k), 64'(bus_b.done), 64'(k == 14));
         chk($sformatf("lat c%0d busy", k), 64'(bus_b.busy), 64'(k <= 13));
         chk($sformatf("lat c%0d input_ready", k), 64'(bus_b.input_ready),
             64'(k >= 3 && k <= 10));
         chk($sformatf("lat c%0d mv_x_out", k), 64'(bus_b.mv_x_out),
             64'((k >= 14) ? 3'd6 : 3'd0));
         chk($sformatf("lat c%0d mv_y_out", k), 64'(bus_b.mv_y_out),
             64'((k >= 14) ? 3'd5 : 3'd0));
         bus_b.mvx = (k == 13) ? 3'd6 : 3'd1;
         bus_b.mvy = (k == 13) ? 3'd5 : 3'd2;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frac_block_feeder.md
Name: frac_block_feeder

Overview:
- Transmit side of the 8x8 quarter-pel search row stream.
- Fetches an 8x8 current (to-be-filtered) block and the co-located 8x8 reference block from two 64-bit line memories.
- Drives them into the fractional search block as 8 contiguous row beats (filter_pix, ref_pix, input_ready).
- Captures the returned mvx/mvy into a result register and signals done; sits between the frame line memories and the fractional search engine.

Parameters:
- ADDR_W, 12, line-memory word address width (one word = 8 pixels x 8 bits).
- RESULT_LAT, 1, cycles from the last input_ready beat until mvx/mvy are valid at the search block.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request; sampled only while busy=0.
- cur_base  in  ADDR_W  word address of row 0 of the current block.
- ref_base  in  ADDR_W  word address of row 0 of the reference block.
- stride  in  ADDR_W  word distance between consecutive block rows.
- cur_rd_en  out  1  current-memory read strobe.
- cur_addr  out  ADDR_W  current-memory read address.
- cur_data  in  64  current-memory read data, valid 1 cycle after cur_rd_en.
- ref_rd_en  out  1  reference-memory read strobe.
- ref_addr  out  ADDR_W  reference-memory read address.
- ref_data  in  64  reference-memory read data, valid 1 cycle after ref_rd_en.
- filter_pix  out  64  row beat to search block, pixel 0 in bits [7:0].
- ref_pix  out  64  reference row beat, same packing.
- input_ready  out  1  beat valid.
- mvx  in  3  search result, x.
- mvy  in  3  search result, y.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse: result captured.
- mv_x_out  out  3  captured mvx.
- mv_y_out  out  3  captured mvy.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: rd_en, addr, pix, input_ready, busy, done, mv_*_out.
- States: IDLE, FETCH, DRAIN, WAIT_RES.
- IDLE: start=1 at edge E0 latches cur_base, ref_base and stride, clears row counter, sets busy=1, goes to FETCH. start while busy=1 is ignored and not queued.
- FETCH, cycles 1..8 after E0:
  - cur_rd_en = ref_rd_en = 1.
  - Row r addresses = base + r*stride, built by accumulating stride (no multiplier), modulo 2^ADDR_W; wrap is silent.
  - After row 7 is issued, go to DRAIN.
- Data path: cur_data/ref_data are registered into filter_pix/ref_pix with input_ready=1 in the cycle after data return.
  - input_ready is high for exactly 8 consecutive cycles, cycles 3..10 after E0.
  - No gaps: the receiver has no backpressure.
  - filter_pix/ref_pix hold the last value when input_ready=0.
- DRAIN: waits until the 8th beat has been emitted, then enters WAIT_RES with a counter loaded to RESULT_LAT.
- WAIT_RES: counter decrements each cycle. At 0, mvx/mvy are sampled into mv_x_out/mv_y_out, done=1 for one cycle, busy=0 in that same cycle, state goes to IDLE.
- mv_x_out/mv_y_out hold their values until the next capture.
- start asserted in the done cycle is accepted (busy already 0). Back-to-back blocks: 8 beats, then RESULT_LAT+3-cycle bubble minimum.
- Reset mid-operation: immediate abort, input_ready drops asynchronously, no done pulse.
- Base/stride inputs may change freely after E0; only the latched copies are used.

Decomposition:
- Package frac_pkg:
  - ROWS=8, PIX_W=8, ROW_W=64.
  - Feeder state encoding.
  - Row-counter width 3.
- Sub-module frac_addr_gen: latches base/stride on load and emits the accumulated row address, one instance per memory.

Test Plan:
- Basic: cur_base=0x010, ref_base=0x200, stride=0x040, start -> addresses 0x010,0x050,...,0x1D0 and 0x200,0x240,...,0x3C0 on cycles 1..8. input_ready high cycles 3..10 with data matching memory model rows 0..7. done at cycle 10+RESULT_LAT+1; mv_x_out/mv_y_out = model mvx=3, mvy=0.
- Wrap: cur_base=0xFC0, stride=0x020 (ADDR_W=12) -> row addresses 0xFC0,0xFE0,0x000,...,0x0A0; no error flag.
- Busy start: start pulsed again at cycles 2 and 6 -> ignored; exactly 8 beats and one done.
- Back-to-back: second start in done cycle -> accepted; second burst's first input_ready 3 cycles later; mv_*_out updated only at second done.
- Reset mid-stream: reset=0 at cycle 5 -> all outputs 0 immediately; after release, no done. A new start produces a full clean 8-beat burst.
- Result latency: RESULT_LAT=3 -> done exactly 2 cycles later than the RESULT_LAT=1 run; mv sampled at that cycle only (model changes mvx one cycle earlier/later must not be captured).
